// File: rtl/sim_run_ctrl_if.sv
// Bundle of run-controller signals between the bench (master) and sim_run_ctrl (slave).
//   start/pc/inst_commit/cpu_ebreak_sign/stop_ack : bench -> controller
//   run_state/stop_req/stop_cause/heartbeat       : controller -> bench, run status
//   cycle_cnt/commit_cnt/last_pc                  : controller -> bench, run statistics
interface sim_run_ctrl_if #(
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned CNT_W    = 32
) ();
  logic                start;
  logic [DATA_LEN-1:0] pc;
  logic                inst_commit;
  logic                cpu_ebreak_sign;
  logic                stop_ack;
  logic [1:0]          run_state;
  logic                stop_req;
  logic [1:0]          stop_cause;
  logic                heartbeat;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    commit_cnt;
  logic [DATA_LEN-1:0] last_pc;

  modport master (
    output start, pc, inst_commit, cpu_ebreak_sign, stop_ack,
    input  run_state, stop_req, stop_cause, heartbeat, cycle_cnt, commit_cnt, last_pc
  );

  modport slave (
    input  start, pc, inst_commit, cpu_ebreak_sign, stop_ack,
    output run_state, stop_req, stop_cause, heartbeat, cycle_cnt, commit_cnt, last_pc
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences IDLE -> RUN -> DRAIN -> HALT from commit/ebreak activity,
// enforces a cycle budget and a commit-stall watchdog, emits heartbeat pulses and holds a stop
// request with a cause code until the bench acknowledges it.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sim_run_ctrl_if.slave (inputs start/pc/inst_commit/cpu_ebreak_sign/stop_ack,
//           outputs run_state/stop_req/stop_cause/heartbeat/cycle_cnt/commit_cnt/last_pc)
module sim_run_ctrl #(
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 400000000,
  parameter int unsigned STALL_LIMIT  = 100000,
  parameter int unsigned HB_PERIOD    = 32'h300000,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input logic          clock,
  input logic          reset,
  sim_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CycLast   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] StallLast = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] HbLast    = CNT_W'(HB_PERIOD - 1);
  localparam logic [CNT_W-1:0] DrainInit = CNT_W'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    commit_q, commit_d;
  logic [DATA_LEN-1:0] last_pc_q, last_pc_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    hb_q, hb_d;
  logic [CNT_W-1:0]    drain_q, drain_d;
  logic                heartbeat_q, heartbeat_d;
  logic                stop_req_q, stop_req_d;
  logic [1:0]          trig;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cycle_q     <= '0;
      commit_q    <= '0;
      last_pc_q   <= '0;
      cause_q     <= 2'd0;
      stall_q     <= '0;
      hb_q        <= '0;
      drain_q     <= '0;
      heartbeat_q <= 1'b0;
      stop_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      commit_q    <= commit_d;
      last_pc_q   <= last_pc_d;
      cause_q     <= cause_d;
      stall_q     <= stall_d;
      hb_q        <= hb_d;
      drain_q     <= drain_d;
      heartbeat_q <= heartbeat_d;
      stop_req_q  <= stop_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    commit_d    = commit_q;
    last_pc_d   = last_pc_q;
    cause_d     = cause_q;
    stall_d     = stall_q;
    hb_d        = hb_q;
    drain_d     = drain_q;
    heartbeat_d = 1'b0;
    trig        = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StRun;
          cycle_d   = '0;
          commit_d  = '0;
          last_pc_d = '0;
          cause_d   = 2'd0;
          stall_d   = '0;
          hb_d      = '0;
        end
      end

      StRun, StDrain: begin
        if (cycle_q != CntMax) cycle_d = cycle_q + 1'b1;
        if (bus.inst_commit) begin
          if (commit_q != CntMax) commit_d = commit_q + 1'b1;
          last_pc_d = bus.pc;
        end
        // Pulse is registered, so it appears the cycle after the counter wraps.
        if (hb_q >= HbLast) begin
          hb_d        = '0;
          heartbeat_d = 1'b1;
        end else begin
          hb_d = hb_q + 1'b1;
        end

        if (state_q == StRun) begin
          if (bus.inst_commit) stall_d = '0;
          else if (stall_q != CntMax) stall_d = stall_q + 1'b1;

          // Priority: ebreak > stall watchdog > cycle limit.
          if (bus.cpu_ebreak_sign) begin
            trig = 2'd1;
          end else if (STALL_LIMIT != 0 && !bus.inst_commit && stall_q == StallLast) begin
            trig = 2'd2;
          end else if (MAX_CYCLES != 0 && cycle_q == CycLast) begin
            trig = 2'd3;
          end

          if (trig != 2'd0) begin
            cause_d = trig;
            drain_d = DrainInit;
            state_d = (DRAIN_CYCLES == 0) ? StHalt : StDrain;
          end
        end else begin
          // Leaving on value 1 gives exactly DRAIN_CYCLES cycles in DRAIN.
          if (drain_q <= CNT_W'(1)) state_d = StHalt;
          else drain_d = drain_q - 1'b1;
        end
      end

      StHalt: begin
        if (bus.stop_ack) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    stop_req_d = (state_d == StHalt);
  end

  assign bus.run_state  = state_q;
  assign bus.stop_req   = stop_req_q;
  assign bus.stop_cause = cause_q;
  assign bus.heartbeat  = heartbeat_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.commit_cnt = commit_q;
  assign bus.last_pc    = last_pc_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances (different parameter sets) share one stimulus stream and
// are compared every cycle against a run-level behavioural model, plus directed scenario checks.
module tb_sim_run_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sim_run_ctrl_if #(.DATA_LEN(64), .CNT_W(32)) bus_a ();
  sim_run_ctrl_if #(.DATA_LEN(64), .CNT_W(8))  bus_b ();

  sim_run_ctrl #(
    .DATA_LEN(64), .CNT_W(32), .MAX_CYCLES(100), .STALL_LIMIT(8), .HB_PERIOD(16),
    .DRAIN_CYCLES(4)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (bus_a)
  );

  sim_run_ctrl #(
    .DATA_LEN(64), .CNT_W(8), .MAX_CYCLES(0), .STALL_LIMIT(0), .HB_PERIOD(5),
    .DRAIN_CYCLES(0)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct {
    int                phase;      // 0 idle, 1 run, 2 drain, 3 halt
    longint unsigned   cyc;
    longint unsigned   com;
    logic [63:0]       lpc;
    int                cause;
    longint unsigned   since;      // RUN cycles since last commit (or start)
    longint unsigned   drain_left;
    longint unsigned   active;     // RUN+DRAIN cycles this run, unbounded
    bit                hb;
  } mdl_t;

  typedef struct {
    longint unsigned max_c;
    longint unsigned stall_l;
    longint unsigned hb_p;
    longint unsigned drain_c;
    longint unsigned cmax;
  } prm_t;

  mdl_t ma, mb;
  prm_t pa, pb;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic mdl_t step(mdl_t m, prm_t p, bit st, bit cm, logic [63:0] pcv, bit eb,
                                bit ak);
    mdl_t n;
    int   code;
    n    = m;
    n.hb = 1'b0;
    case (m.phase)
      0: if (st) begin
        n.phase  = 1;
        n.cyc    = 0;
        n.com    = 0;
        n.lpc    = '0;
        n.cause  = 0;
        n.since  = 0;
        n.active = 0;
      end
      1, 2: begin
        n.active = m.active + 1;
        n.hb     = (n.active % p.hb_p) == 0;
        n.cyc    = (m.cyc < p.cmax) ? m.cyc + 1 : m.cyc;
        if (cm) begin
          n.com = (m.com < p.cmax) ? m.com + 1 : m.com;
          n.lpc = pcv;
        end
        if (m.phase == 1) begin
          code = 0;
          if (eb) code = 1;
          else if (p.stall_l != 0 && !cm && m.since + 1 == p.stall_l) code = 2;
          else if (p.max_c != 0 && m.cyc + 1 == p.max_c) code = 3;
          n.since = cm ? 0 : m.since + 1;
          if (code != 0) begin
            n.cause      = code;
            n.drain_left = p.drain_c;
            n.phase      = (p.drain_c == 0) ? 3 : 2;
          end
        end else begin
          if (m.drain_left == 1) n.phase = 3;
          else n.drain_left = m.drain_left - 1;
        end
      end
      default: if (ak) n.phase = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_all();
    chk("a.run_state",  64'(bus_a.run_state),  64'(ma.phase));
    chk("a.stop_req",   64'(bus_a.stop_req),   64'(ma.phase == 3));
    chk("a.stop_cause", 64'(bus_a.stop_cause), 64'(ma.cause));
    chk("a.heartbeat",  64'(bus_a.heartbeat),  64'(ma.hb));
    chk("a.cycle_cnt",  64'(bus_a.cycle_cnt),  ma.cyc);
    chk("a.commit_cnt", 64'(bus_a.commit_cnt), ma.com);
    chk("a.last_pc",    bus_a.last_pc,         ma.lpc);
    chk("b.run_state",  64'(bus_b.run_state),  64'(mb.phase));
    chk("b.stop_req",   64'(bus_b.stop_req),   64'(mb.phase == 3));
    chk("b.stop_cause", 64'(bus_b.stop_cause), 64'(mb.cause));
    chk("b.heartbeat",  64'(bus_b.heartbeat),  64'(mb.hb));
    chk("b.cycle_cnt",  64'(bus_b.cycle_cnt),  mb.cyc);
    chk("b.commit_cnt", 64'(bus_b.commit_cnt), mb.com);
    chk("b.last_pc",    bus_b.last_pc,         mb.lpc);
  endtask

  // Called at a falling edge; applies inputs for one cycle and checks just after the rising edge.
  task automatic tick(input bit st, input bit cm, input logic [63:0] pcv, input bit eb,
                      input bit ak);
    bus_a.start = st; bus_a.inst_commit = cm; bus_a.pc = pcv;
    bus_a.cpu_ebreak_sign = eb; bus_a.stop_ack = ak;
    bus_b.start = st; bus_b.inst_commit = cm; bus_b.pc = pcv;
    bus_b.cpu_ebreak_sign = eb; bus_b.stop_ack = ak;
    @(posedge clock);
    ma = step(ma, pa, st, cm, pcv, eb, ak);
    mb = step(mb, pb, st, cm, pcv, eb, ak);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    ma = '{phase: 0, cyc: 0, com: 0, lpc: '0, cause: 0, since: 0, drain_left: 0, active: 0,
           hb: 1'b0};
    mb = ma;
  endtask

  initial begin
    logic [63:0] base;
    base = 64'h8000_0000;
    pa = '{max_c: 100, stall_l: 8, hb_p: 16, drain_c: 4, cmax: 64'hFFFF_FFFF};
    pb = '{max_c: 0, stall_l: 0, hb_p: 5, drain_c: 0, cmax: 64'hFF};
    model_reset();
    bus_a.start = 0; bus_a.inst_commit = 0; bus_a.pc = '0;
    bus_a.cpu_ebreak_sign = 0; bus_a.stop_ack = 0;
    bus_b.start = 0; bus_b.inst_commit = 0; bus_b.pc = '0;
    bus_b.cpu_ebreak_sign = 0; bus_b.stop_ack = 0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    compare_all();
    reset = 1'b1;

    // 1: asynchronous reset in the middle of a run.
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) tick(1'b0, 1'b1, base + 64'(4 * k), 1'b0, 1'b0);
    chk("t1.cycle_before_reset", 64'(bus_a.cycle_cnt), 64'd50);
    reset = 1'b0;
    #1;
    chk("t1.run_state", 64'(bus_a.run_state), 64'd0);
    chk("t1.stop_req",  64'(bus_a.stop_req),  64'd0);
    chk("t1.cycle_cnt", 64'(bus_a.cycle_cnt), 64'd0);
    chk("t1.last_pc",   bus_a.last_pc,        64'd0);
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b1;

    // 2: ten commits, ebreak alongside the tenth; 4 drain cycles then HALT.
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, base + 64'(4 * k), k == 9, 1'b0);
    chk("t2.cause",      64'(bus_a.stop_cause), 64'd1);
    chk("t2.commit_cnt", 64'(bus_a.commit_cnt), 64'd10);
    chk("t2.last_pc",    bus_a.last_pc,         64'h8000_0024);
    chk("t2.state",      64'(bus_a.run_state),  64'd2);
    chk("t6.b_no_drain", 64'(bus_b.run_state),  64'd3);
    for (int k = 1; k <= 4; k++) begin
      idle_tick();
      chk("t2.stop_req", 64'(bus_a.stop_req), 64'(k == 4));
    end
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("t2.ack_idle",   64'(bus_a.run_state),  64'd0);
    chk("t2.cause_kept", 64'(bus_a.stop_cause), 64'd1);
    chk("t2.count_kept", 64'(bus_a.commit_cnt), 64'd10);

    // 3: stall watchdog; a commit on the 7th idle cycle restarts the count.
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, base + 64'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) idle_tick();
    tick(1'b0, 1'b1, base + 64'h100, 1'b0, 1'b0);
    chk("t3.no_trip", 64'(bus_a.run_state), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      idle_tick();
      chk("t3.state", 64'(bus_a.run_state), (k < 8) ? 64'd1 : 64'd2);
    end
    chk("t3.cause", 64'(bus_a.stop_cause), 64'd2);
    for (int k = 0; k < 4; k++) idle_tick();
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);  // ends dut_b's run; dut_a idle ignores it
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // 4/5/6: cycle limit, heartbeat, ignored start/ack in RUN.
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 100; n++) begin
      tick(n == 50, 1'b1, base + 64'(4 * n), 1'b0, n == 60);
      if (n <= 40) chk("t5.heartbeat", 64'(bus_a.heartbeat), 64'(n == 16 || n == 32));
      if (n == 50) chk("t6.start_in_run", 64'(bus_a.cycle_cnt), 64'd50);
      if (n == 60) chk("t6.ack_in_run", 64'(bus_a.run_state), 64'd1);
    end
    chk("t4.state", 64'(bus_a.run_state),  64'd2);
    chk("t4.cause", 64'(bus_a.stop_cause), 64'd3);
    chk("t4.cycle", 64'(bus_a.cycle_cnt),  64'd100);
    for (int k = 0; k < 4; k++) idle_tick();
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("t6.start_in_halt", 64'(bus_a.run_state), 64'd3);
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
    chk("t6.start_ack_idle", 64'(bus_a.run_state), 64'd0);
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("t6.restart_cycle", 64'(bus_a.cycle_cnt),  64'd0);
    chk("t6.restart_cause", 64'(bus_a.stop_cause), 64'd0);
    // ebreak, stall and limit all fire on cycle 100: ebreak wins.
    for (int n = 1; n <= 100; n++) tick(1'b0, n <= 92, base + 64'(4 * n), n == 100, 1'b0);
    chk("t4.prio_cause", 64'(bus_a.stop_cause), 64'd1);
    for (int k = 0; k < 4; k++) idle_tick();
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // Counter saturation on the 8-bit instance.
    tick(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 300; n++) tick(1'b0, 1'b1, base + 64'(4 * n), 1'b0, 1'b0);
    chk("sat.cycle",  64'(bus_b.cycle_cnt),  64'd255);
    chk("sat.commit", 64'(bus_b.commit_cnt), 64'd255);
    tick(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, {$urandom, $urandom},
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
